// File: rtl/read_miss_fill_handler_pkg.sv
// ============================================================================
// Module   : dram_cache_pkg
// Brief    : Shared widths, entry type and helpers for the read-miss fill path
// Revision : 1.0 - buffered multi-entry fill handler
// ============================================================================
`default_nettype none

`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

package dram_cache_pkg;

  localparam int AXI_ADDR_WIDTH = `AXI_ADDR_WIDTH;
  localparam int AXI_DATA_WIDTH = `AXI_DATA_WIDTH;
  localparam int RMH_DEPTH      = 4;

  typedef struct packed {
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [AXI_DATA_WIDTH-1:0] data;
  } rmh_entry_t;

  function automatic int rmh_ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/read_miss_fill_handler_if.sv
// ============================================================================
// Module   : read_miss_fill_handler_if
// Brief    : CXL return, R_MISS_FIFO, ROB and Arbiter handshakes of the handler
// Revision : 1.0 - buffered multi-entry fill handler
// ============================================================================
`default_nettype none

interface read_miss_fill_handler_if
  import dram_cache_pkg::*;
#(
  parameter int ADDR_WIDTH = AXI_ADDR_WIDTH,
  parameter int DATA_WIDTH = AXI_DATA_WIDTH
);
  localparam int WDATA_WIDTH = ADDR_WIDTH + DATA_WIDTH;

  logic                   valid_i;
  logic                   ready_o;
  logic [DATA_WIDTH-1:0]  data_i;
  logic                   read_en_o;
  logic                   empty_i;
  logic [ADDR_WIDTH-1:0]  ar_i;
  logic                   write_en_o;
  logic                   full_i;
  logic [WDATA_WIDTH-1:0] wdata_ROB_o;
  logic                   valid_o;
  logic                   ready_i;
  logic [WDATA_WIDTH-1:0] wdata_Arbiter_o;

  modport slave (
    input  valid_i, data_i, empty_i, ar_i, full_i, ready_i,
    output ready_o, read_en_o, write_en_o, wdata_ROB_o, valid_o, wdata_Arbiter_o
  );

  modport master (
    output valid_i, data_i, empty_i, ar_i, full_i, ready_i,
    input  ready_o, read_en_o, write_en_o, wdata_ROB_o, valid_o, wdata_Arbiter_o
  );

endinterface

`default_nettype wire

// File: rtl/read_miss_fill_handler_entry_buf.sv
// ============================================================================
// Module   : rmh_entry_buf
// Brief    : DEPTH-entry {addr,data} store, tail write / head read, pend bits
// Revision : 1.0 - buffered multi-entry fill handler
// ============================================================================
`default_nettype none

module rmh_entry_buf
  import dram_cache_pkg::*;
#(
  parameter int WDATA_WIDTH = AXI_ADDR_WIDTH + AXI_DATA_WIDTH,
  parameter int DEPTH       = RMH_DEPTH,
  parameter int PTR_W       = rmh_ptr_width(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [PTR_W-1:0]       wr_ptr,
  input  logic [WDATA_WIDTH-1:0] wr_data,
  input  logic                   wr_arb_pend,
  input  logic [PTR_W-1:0]       rd_ptr,
  input  logic                   clr_rob,
  input  logic                   clr_arb,
  output logic [WDATA_WIDTH-1:0] rd_data,
  output logic                   rd_rob_pend,
  output logic                   rd_arb_pend
);

  logic [WDATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]       r_rob_pend;
  logic [DEPTH-1:0]       r_arb_pend;

  // Payload needs no reset: it is only observed while its pend bits are set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_ptr] <= wr_data;
    end
  end

  // Tail write and head clear never hit the same slot: a write needs a free
  // slot, a clear needs a live head, and head==tail then implies empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rob_pend <= '0;
      r_arb_pend <= '0;
    end else begin
      if (clr_rob) r_rob_pend[rd_ptr] <= 1'b0;
      if (clr_arb) r_arb_pend[rd_ptr] <= 1'b0;
      if (wr_en) begin
        r_rob_pend[wr_ptr] <= 1'b1;
        r_arb_pend[wr_ptr] <= wr_arb_pend;
      end
    end
  end

  assign rd_data     = r_mem[rd_ptr];
  assign rd_rob_pend = r_rob_pend[rd_ptr];
  assign rd_arb_pend = r_arb_pend[rd_ptr];

endmodule

`default_nettype wire

// File: rtl/read_miss_fill_handler.sv
// ============================================================================
// Module   : read_miss_fill_handler
// Brief    : Pairs CXL return beats with R_MISS_FIFO addresses, buffers them
//            and dispatches in order to the ROB and (optionally) fill Arbiter
// Revision : 1.0 - buffered multi-entry fill handler
// ============================================================================
`default_nettype none

module read_miss_fill_handler
  import dram_cache_pkg::*;
#(
  parameter int ADDR_WIDTH  = AXI_ADDR_WIDTH,
  parameter int DATA_WIDTH  = AXI_DATA_WIDTH,
  parameter int WDATA_WIDTH = ADDR_WIDTH + DATA_WIDTH,
  parameter int DEPTH       = RMH_DEPTH,
  parameter bit FILL_EN     = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  read_miss_fill_handler_if.slave   bus,
  output logic [$clog2(DEPTH):0]    occupancy_o,
  output logic                      err_o
);

  localparam int PTR_W = rmh_ptr_width(DEPTH);
  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam logic [OCC_W-1:0] c_full = OCC_W'(DEPTH);

  logic [PTR_W-1:0]       r_head;
  logic [PTR_W-1:0]       r_tail;
  logic [OCC_W-1:0]       r_occ;
  logic                   r_err;

  logic                   w_ready;
  logic                   w_accept;
  logic                   w_drop;
  logic                   w_nonempty;
  logic                   w_rob_go;
  logic                   w_arb_valid;
  logic                   w_arb_go;
  logic                   w_retire;
  logic [WDATA_WIDTH-1:0] w_head_data;
  logic                   w_head_rob;
  logic                   w_head_arb;

  // Ready depends on occupancy alone, so a same-cycle retire cannot open it.
  assign w_ready    = (r_occ != c_full);
  assign w_accept   = bus.valid_i & w_ready & ~bus.empty_i;
  assign w_drop     = bus.valid_i & w_ready & bus.empty_i;
  assign w_nonempty = (r_occ != '0);

  assign w_rob_go    = w_nonempty & w_head_rob & ~bus.full_i;
  assign w_arb_valid = FILL_EN & w_nonempty & w_head_arb;
  assign w_arb_go    = w_arb_valid & bus.ready_i;

  // Head leaves once neither side still owes a delivery after this cycle.
  assign w_retire = w_nonempty
                  & ~(w_head_rob & ~w_rob_go)
                  & ~(w_head_arb & ~w_arb_go);

  rmh_entry_buf #(
    .WDATA_WIDTH (WDATA_WIDTH),
    .DEPTH       (DEPTH),
    .PTR_W       (PTR_W)
  ) u_entry_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (w_accept),
    .wr_ptr      (r_tail),
    .wr_data     ({bus.ar_i, bus.data_i}),
    .wr_arb_pend (FILL_EN),
    .rd_ptr      (r_head),
    .clr_rob     (w_rob_go),
    .clr_arb     (w_arb_go),
    .rd_data     (w_head_data),
    .rd_rob_pend (w_head_rob),
    .rd_arb_pend (w_head_arb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_accept) r_tail <= r_tail + 1'b1;
      if (w_retire) r_head <= r_head + 1'b1;
      case ({w_accept, w_retire})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
      if (w_drop) r_err <= 1'b1;
    end
  end

  assign bus.ready_o         = w_ready;
  assign bus.read_en_o       = w_accept;
  assign bus.write_en_o      = w_rob_go;
  assign bus.wdata_ROB_o     = w_nonempty ? w_head_data : '0;
  assign bus.valid_o         = w_arb_valid;
  assign bus.wdata_Arbiter_o = (FILL_EN && w_nonempty) ? w_head_data : '0;
  assign occupancy_o         = r_occ;
  assign err_o               = r_err;

endmodule

`default_nettype wire

// File: tb/tb_read_miss_fill_handler.sv
// ============================================================================
// Module   : tb_read_miss_fill_handler
// Brief    : Scoreboard bench for FILL_EN=1 and FILL_EN=0 handler builds
// Revision : 1.0 - buffered multi-entry fill handler
// ============================================================================
`default_nettype none

module tb_read_miss_fill_handler;
  import dram_cache_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] occ1, occ0;
  logic       err1, err0;

  read_miss_fill_handler_if bus ();
  read_miss_fill_handler_if bus0 ();

  read_miss_fill_handler #(.DEPTH(4), .FILL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .occupancy_o(occ1), .err_o(err1)
  );
  read_miss_fill_handler #(.DEPTH(4), .FILL_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .occupancy_o(occ0), .err_o(err0)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_re     = 0;
  int n_we     = 0;
  logic [63:0] rob_q[$];
  logic [63:0] arb_q[$];
  logic [63:0] rob0_q[$];
  logic        prev_hold = 1'b0;
  logic [63:0] prev_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s: output asserted with no expected entry", name);
  endtask

  function automatic logic [63:0] entry(input logic [31:0] a, input logic [31:0] d);
    rmh_entry_t e;
    e.addr = a;
    e.data = d;
    return e;
  endfunction

  // Monitor: pops the scoreboard whenever a consumer handshake completes.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (bus.read_en_o) n_re++;
      if (bus.write_en_o) begin
        n_we++;
        if (rob_q.size() == 0) fail("rob_unexpected");
        else check("rob_wdata", bus.wdata_ROB_o, rob_q.pop_front());
      end
      if (prev_hold) begin
        check("arb_hold_valid", bus.valid_o, 1);
        check("arb_hold_data", bus.wdata_Arbiter_o, prev_data);
      end
      if (bus.valid_o && bus.ready_i) begin
        if (arb_q.size() == 0) fail("arb_unexpected");
        else check("arb_wdata", bus.wdata_Arbiter_o, arb_q.pop_front());
      end
      prev_hold = bus.valid_o && !bus.ready_i;
      prev_data = bus.wdata_Arbiter_o;
      if (bus0.write_en_o) begin
        if (rob0_q.size() == 0) fail("rob0_unexpected");
        else check("rob0_wdata", bus0.wdata_ROB_o, rob0_q.pop_front());
        check("fill0_arb_data", bus0.wdata_Arbiter_o, 0);
      end
      if (bus0.valid_o) fail("fill0_valid");
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] a, input logic [31:0] d, input bit exp_acc);
    bus.valid_i = 1'b1; bus.ar_i = a; bus.data_i = d; bus.empty_i = 1'b0;
    #1;
    check("read_en", bus.read_en_o, exp_acc);
    if (exp_acc) begin
      rob_q.push_back(entry(a, d));
      arb_q.push_back(entry(a, d));
    end
    step();
    bus.valid_i = 1'b0; bus.empty_i = 1'b1;
  endtask

  task automatic beat0(input logic [31:0] a, input logic [31:0] d);
    bus0.valid_i = 1'b1; bus0.ar_i = a; bus0.data_i = d; bus0.empty_i = 1'b0;
    #1;
    check("read_en0", bus0.read_en_o, 1);
    rob0_q.push_back(entry(a, d));
    step();
    bus0.valid_i = 1'b0; bus0.empty_i = 1'b1;
  endtask

  task automatic wait_empty(input string name);
    for (int i = 0; i < 50 && occ1 != 0; i++) step();
    check(name, occ1, 0);
  endtask

  task automatic wait_empty0(input string name);
    for (int i = 0; i < 50 && occ0 != 0; i++) step();
    check(name, occ0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int re0;
    int we0;
    bus.valid_i = 0;  bus.data_i = 0;  bus.empty_i = 1;  bus.ar_i = 0;
    bus.full_i = 0;   bus.ready_i = 0;
    bus0.valid_i = 0; bus0.data_i = 0; bus0.empty_i = 1; bus0.ar_i = 0;
    bus0.full_i = 0;  bus0.ready_i = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_occ", occ1, 0);
    check("rst_ready", bus.ready_o, 1);
    check("rst_err", err1, 0);
    check("rst_write_en", bus.write_en_o, 0);
    check("rst_valid", bus.valid_o, 0);
    check("rst_wdata_rob", bus.wdata_ROB_o, 0);
    check("rst_wdata_arb", bus.wdata_Arbiter_o, 0);
    rst_n = 1'b1;
    step();

    // Single miss: visible the cycle after accept, retires one cycle later.
    bus.ready_i = 1; bus.full_i = 0;
    beat(32'h1000, 32'hAA, 1);
    check("single_occ1", occ1, 1);
    check("single_we", bus.write_en_o, 1);
    check("single_valid", bus.valid_o, 1);
    step();
    check("single_occ0", occ1, 0);

    // Back-pressure fill, then release consumers in the same cycle as a 5th beat.
    bus.ready_i = 0; bus.full_i = 1;
    re0 = n_re;
    beat(32'h2000, 32'h20, 1);
    beat(32'h2001, 32'h21, 1);
    beat(32'h2002, 32'h22, 1);
    beat(32'h2003, 32'h23, 1);
    check("bp_occ4", occ1, 4);
    check("bp_ready_full", bus.ready_o, 0);
    bus.valid_i = 1; bus.ar_i = 32'h2004; bus.data_i = 32'h24; bus.empty_i = 0;
    bus.full_i = 0; bus.ready_i = 1;
    #1;
    check("bp_ready_no_bypass", bus.ready_o, 0);
    check("bp_read_en_5th", bus.read_en_o, 0);
    step();
    bus.valid_i = 0; bus.empty_i = 1;
    check("bp_occ_after_retire", occ1, 3);
    check("bp_read_en_pulses", n_re - re0, 4);
    wait_empty("bp_drain");

    // Independent completion: ROB side done, Arbiter held for 3 cycles.
    bus.full_i = 0; bus.ready_i = 0;
    we0 = n_we;
    beat(32'h3000, 32'h33, 1);
    step();
    step();
    check("ind_we_once", n_we - we0, 1);
    check("ind_occ_held", occ1, 1);
    check("ind_valid_held", bus.valid_o, 1);
    bus.ready_i = 1;
    step();
    check("ind_retired", occ1, 0);

    // Ordering and wrap under pseudo-random consumer stalls.
    acc = 0;
    for (int cyc = 0; cyc < 300 && acc < 10; cyc++) begin
      bus.ready_i = 1'($urandom_range(0, 1));
      bus.full_i  = 1'($urandom_range(0, 1));
      bus.valid_i = 1; bus.ar_i = acc; bus.data_i = 32'hD0 + acc; bus.empty_i = 0;
      #1;
      if (bus.ready_o) begin
        rob_q.push_back(entry(acc, 32'hD0 + acc));
        arb_q.push_back(entry(acc, 32'hD0 + acc));
        acc++;
      end
      step();
    end
    bus.valid_i = 0; bus.empty_i = 1;
    check("order_accepted", acc, 10);
    bus.ready_i = 1; bus.full_i = 0;
    wait_empty("order_drain");
    check("order_rob_q_empty", rob_q.size(), 0);
    check("order_arb_q_empty", arb_q.size(), 0);

    // Return beat with no outstanding miss.
    bus.valid_i = 1; bus.empty_i = 1; bus.ar_i = 32'h5000; bus.data_i = 32'h55;
    #1;
    check("err_no_read_en", bus.read_en_o, 0);
    step();
    bus.valid_i = 0;
    check("err_set", err1, 1);
    check("err_no_entry", occ1, 0);
    repeat (3) step();
    check("err_sticky", err1, 1);

    // FILL_EN=0: ROB-only delivery.
    bus0.full_i = 0;
    beat0(32'h6000, 32'h60);
    beat0(32'h6001, 32'h61);
    beat0(32'h6002, 32'h62);
    wait_empty0("fill0_drain");
    check("fill0_q_empty", rob0_q.size(), 0);

    // Queue 3 in each build, then reset asynchronously mid-cycle.
    bus.ready_i = 0; bus.full_i = 1; bus0.full_i = 1;
    beat(32'h7000, 32'h70, 1);
    beat(32'h7001, 32'h71, 1);
    beat(32'h7002, 32'h72, 1);
    beat0(32'h7100, 32'h80);
    beat0(32'h7101, 32'h81);
    beat0(32'h7102, 32'h82);
    check("pre_rst_occ", occ1, 3);
    check("pre_rst_occ0", occ0, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_occ", occ1, 0);
    check("mid_rst_ready", bus.ready_o, 1);
    check("mid_rst_occ0", occ0, 0);
    check("mid_rst_ready0", bus0.ready_o, 1);
    check("mid_rst_err", err1, 0);
    check("mid_rst_valid", bus.valid_o, 0);
    rob_q.delete(); arb_q.delete(); rob0_q.delete();
    step();
    step();
    rst_n = 1'b1;
    bus.ready_i = 1; bus.full_i = 0; bus0.full_i = 0;
    repeat (3) step();
    check("post_rst_idle_occ", occ1, 0);
    check("post_rst_idle_we", bus.write_en_o, 0);

    // Fresh traffic after reset.
    beat(32'h8000, 32'h88, 1);
    wait_empty("post_rst_drain");
    check("final_rob_q", rob_q.size(), 0);
    check("final_arb_q", arb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/read_miss_fill_handler.md
Name: read_miss_fill_handler

Overview:
- Buffered, parametrised successor of the single-entry read-miss handler in the DRAM cache miss path.
- Pairs each CXL read-return beat with the oldest address popped from the R_MISS_FIFO.
- Delivers each {addr,data} pair to the ROB (response path) and, when FILL_EN=1, to the fill Arbiter (cache install).
- Holds up to DEPTH outstanding pairs, so one slow consumer does not stall CXL returns until the buffer is full.

Parameters:
ADDR_WIDTH, `AXI_ADDR_WIDTH, miss address width
DATA_WIDTH, `AXI_DATA_WIDTH, line/beat data width
WDATA_WIDTH, ADDR_WIDTH+DATA_WIDTH, packed entry width {addr,data}
DEPTH, 4, staging entries; power of two, >=2
FILL_EN, 1, 1 = entry must also be sent to Arbiter; 0 = ROB only, valid_o tied 0

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
valid_i  in  1  CXL return data valid
ready_o  out  1  handler can accept a return beat
data_i  in  DATA_WIDTH  CXL return data
read_en_o  out  1  pop R_MISS_FIFO this cycle
empty_i  in  1  R_MISS_FIFO empty
ar_i  in  ADDR_WIDTH  R_MISS_FIFO head address (show-ahead)
write_en_o  out  1  ROB push
full_i  in  1  ROB full
wdata_ROB_o  out  WDATA_WIDTH  ROB entry {addr,data}
valid_o  out  1  Arbiter request valid
ready_i  in  1  Arbiter accepts
wdata_Arbiter_o  out  WDATA_WIDTH  Arbiter entry {addr,data}
occupancy_o  out  $clog2(DEPTH)+1  live entries
err_o  out  1  sticky: data returned with no outstanding miss

Behaviour:
Reset (rst_n low, async):
- Buffer pointers, occupancy, pending bits and err_o clear.
- Outputs read 0, except ready_o=1; wdata outputs 0.

Accept:
- ready_o = (occupancy != DEPTH), registered-free combinational from state.
- Beat accepted when valid_i & ready_o & !empty_i.
- In the same cycle: read_en_o=1 (combinational), entry {ar_i,data_i} written at tail, rob_pend=1, arb_pend=FILL_EN.
- read_en_o is never asserted without an accept.
- valid_i & ready_o & empty_i: beat dropped, err_o set until reset.

Dispatch (in-order, head entry only):
- write_en_o = occupancy!=0 & rob_pend[head] & !full_i; on assertion clear rob_pend[head].
- valid_o = occupancy!=0 & arb_pend[head]; valid_o stays asserted and wdata stable until ready_i.
- On valid_o & ready_i, clear arb_pend[head].
- Both sides may complete in the same cycle or in either order.
- Head retires in the cycle its last pending bit clears. The head advances and next-cycle outputs show the new head.

Latency and throughput:
- Accept in cycle N with an empty buffer gives outputs visible in N+1.
- Sustained throughput is 1 entry/cycle when full_i=0 and ready_i=1.

Simultaneous events:
- Accept and retire in one cycle: occupancy unchanged.
- When full, ready_o=0; a retire in the same cycle does NOT enable accept (no combinational ready path from consumers).

Wrap-around:
- Pointers are $clog2(DEPTH) bits and wrap naturally.
- Occupancy is tracked separately, with 0..DEPTH range.

full_i behaviour:
- full_i high holds ROB dispatch.
- The Arbiter path still proceeds, and vice versa.

FILL_EN=0:
- arb_pend is never set; valid_o=0; wdata_Arbiter_o=0.

Reset mid-operation:
- All in-flight entries are discarded.
- No outputs asserted after reset until a new accept.

Decomposition:
- Package dram_cache_pkg: rmh_entry_t (packed addr/data struct), DEPTH default constant, pointer-width function.
- One natural sub-module: rmh_entry_buf, a DEPTH-entry storage array with tail write and head read plus per-entry pend bits. Top holds pointers, control and err logic.

Test Plan:
- Single miss: ar_i=0x1000, data_i=0xAA on one valid_i pulse, ready_i=1, full_i=0 -> read_en_o in the same cycle; next cycle write_en_o=1 and valid_o=1 with wdata={0x1000,0xAA}; occupancy 1->0.
- Back-pressure fill: ready_i=0, full_i=1, 5 returns with DEPTH=4 -> 4 accepted, ready_o=0 on the 5th, read_en_o exactly 4 pulses, occupancy_o=4.
- Independent completion: full_i=0, ready_i low for 3 cycles -> write_en_o pulses once only; entry retires when ready_i rises; valid_o held stable meanwhile.
- Ordering/wrap: 10 sequential addresses 0x0..0x9 under random ready_i/full_i -> ROB and Arbiter each see 0x0..0x9 in order, no duplicates.
- Error: valid_i=1 with empty_i=1 -> no read_en_o, no entry, err_o=1 and sticky until rst_n.
- FILL_EN=0 build and async reset mid-stream: ROB-only delivery with valid_o never asserted; rst_n low with 3 entries queued -> occupancy_o=0, ready_o=1 immediately.
